// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the memory-side
// slave. The "master" modport is the arbiter's view: it masters the memory
// bus (drives s_*) and answers the two requesters. The "slave" modport is the
// opposite view, used by whatever surrounds the arbiter (masters + memory).
interface bus_arbiter_if;
   // Requester side
   logic [7:0] m0_address;
   logic [7:0] m1_address;
   logic [7:0] m0_data_out;
   logic [7:0] m1_data_out;
   logic       m0_read;
   logic       m1_read;
   logic       m0_write;
   logic       m1_write;
   logic [7:0] m0_data_in;
   logic [7:0] m1_data_in;
   logic       m0_ready;
   logic       m1_ready;
   // Memory side
   logic [7:0] s_address;
   logic [7:0] s_data_out;
   logic       s_read;
   logic       s_write;
   logic [7:0] s_data_in;
   logic       s_ready;
   // Status
   logic       grant;
   logic       busy;
   logic       bus_error;
   logic       dbg_state;

   modport master (
      input  m0_address, m1_address, m0_data_out, m1_data_out,
      input  m0_read, m1_read, m0_write, m1_write,
      output m0_data_in, m1_data_in, m0_ready, m1_ready,
      output s_address, s_data_out, s_read, s_write,
      input  s_data_in, s_ready,
      output grant, busy, bus_error, dbg_state
   );

   modport slave (
      output m0_address, m1_address, m0_data_out, m1_data_out,
      output m0_read, m1_read, m0_write, m1_write,
      input  m0_data_in, m1_data_in, m0_ready, m1_ready,
      input  s_address, s_data_out, s_read, s_write,
      output s_data_in, s_ready,
      input  grant, busy, bus_error, dbg_state
   );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave round-robin arbiter for the 8-bit memory
// bus. A grant is held for one complete s_ready-terminated transaction.
//
// Handshake: a master raises read and/or write with address/data stable and
// holds them until its mN_ready pulses for one cycle; that pulse is the only
// completion indication. The slave sees registered s_* strobes held constant
// while busy and ends the transaction by asserting s_ready for one cycle.
//
// Optional build macro BUS_ARB_TIMEOUT_EN: aborts a transaction after TIMEOUT
// BUSY cycles without s_ready (owner gets ready with data 8'hFF and bus_error
// pulses). Without it, BUSY waits indefinitely and bus_error is tied low.
module bus_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input logic         clk,
   input logic         reset,
   bus_arbiter_if.master bus
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic       last;
   logic       grant_q;
   logic [7:0] s_address_q;
   logic [7:0] s_data_out_q;
   logic       s_read_q;
   logic       s_write_q;

   logic       req0;
   logic       req1;
   logic       any_req;
   logic       win;
   logic       abort;
   logic       finish;
   logic [7:0] rdata;

   // TIMEOUT must fit the 8-bit counter and be non-zero
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("bus_arbiter: TIMEOUT out of range 1..255");
   end

   assign req0    = bus.m0_read | bus.m0_write;
   assign req1    = bus.m1_read | bus.m1_write;
   assign any_req = req0 | req1;
   // On a tie the master that did not win last time gets the bus
   assign win     = (req0 & req1) ? ~last : req1;

`ifdef BUS_ARB_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   assign abort = (state == BUSY) && !bus.s_ready && (tmo_cnt == 8'(TIMEOUT));

   // Count BUSY cycles without s_ready; held at zero outside BUSY
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt <= 8'd0;
      end else if (state == BUSY && !bus.s_ready && !abort) begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end else begin
         tmo_cnt <= 8'd0;
      end
   end
`else
   assign abort = 1'b0;
`endif

   // A transaction ends on slave completion or on a timeout abort
   assign finish = (state == BUSY) && (bus.s_ready || abort);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state: grant when anyone asks, release on completion
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = BUSY;
         BUSY:    if (finish)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the winner's request on grant; drop strobes on completion
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q      <= 1'b0;
         last         <= 1'b1;
         s_address_q  <= 8'h00;
         s_data_out_q <= 8'h00;
         s_read_q     <= 1'b0;
         s_write_q    <= 1'b0;
      end else if (state == IDLE && any_req) begin
         grant_q      <= win;
         last         <= win;
         s_address_q  <= win ? bus.m1_address  : bus.m0_address;
         s_data_out_q <= win ? bus.m1_data_out : bus.m0_data_out;
         // Read takes precedence when both strobes are raised
         s_read_q     <= win ? bus.m1_read : bus.m0_read;
         s_write_q    <= win ? (bus.m1_write & ~bus.m1_read)
                             : (bus.m0_write & ~bus.m0_read);
      end else if (finish) begin
         s_read_q     <= 1'b0;
         s_write_q    <= 1'b0;
      end
   end

   // Return path: completion and read data steered to the owner only
   assign rdata          = abort ? 8'hFF : bus.s_data_in;
   assign bus.m0_ready   = finish & ~grant_q;
   assign bus.m1_ready   = finish &  grant_q;
   assign bus.m0_data_in = grant_q ? 8'h00 : rdata;
   assign bus.m1_data_in = grant_q ? rdata : 8'h00;

   assign bus.s_address  = s_address_q;
   assign bus.s_data_out = s_data_out_q;
   assign bus.s_read     = s_read_q;
   assign bus.s_write    = s_write_q;
   assign bus.grant      = grant_q;
   assign bus.busy       = (state == BUSY);
   assign bus.bus_error  = abort;
   assign bus.dbg_state  = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. Expected slave-side requests and master
// responses are queued when stimulus is issued; a monitor pops and compares
// on every grant and every ready pulse.
module tb_bus_arbiter;

   localparam int TMO = 15;

   logic clk;
   logic reset;
   bus_arbiter_if bif ();

   bus_arbiter #(.TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // {grant, s_read, s_write, s_address, s_data_out}
   logic [18:0] exp_s_q[$];
   // {owner, data_in, bus_error}
   logic [9:0]  exp_q[$];

   int         req_cyc[2];
   int         grant_cyc[2];
   int         ready_cyc[2];

   int         slave_delay = -1;
   logic [7:0] slave_data = 8'h00;
   bit         idle_noise = 1'b0;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_s(input bit g, input bit rd, input bit wr,
                         input logic [7:0] addr, input logic [7:0] dat);
      exp_s_q.push_back({g, rd, wr, addr, dat});
   endtask

   task automatic push_r(input bit owner, input logic [7:0] dat, input bit err);
      exp_q.push_back({owner, dat, err});
   endtask

   task automatic clear_master(input bit m);
      if (!m) begin
         bif.m0_read = 1'b0; bif.m0_write = 1'b0;
         bif.m0_address = 8'h00; bif.m0_data_out = 8'h00;
      end else begin
         bif.m1_read = 1'b0; bif.m1_write = 1'b0;
         bif.m1_address = 8'h00; bif.m1_data_out = 8'h00;
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      clear_master(1'b0);
      clear_master(1'b1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // ---------------- driver: one master transaction ----------------
   // Called just after a rising edge; holds the request until own ready.
   task automatic master_txn(input bit m, input bit rd, input bit wr,
                             input logic [7:0] addr, input logic [7:0] dat,
                             input int budget);
      bit seen;
      seen = 1'b0;
      if (!m) begin
         bif.m0_read = rd; bif.m0_write = wr;
         bif.m0_address = addr; bif.m0_data_out = dat;
      end else begin
         bif.m1_read = rd; bif.m1_write = wr;
         bif.m1_address = addr; bif.m1_data_out = dat;
      end
      req_cyc[m] = cyc;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = m ? bif.m1_ready : bif.m0_ready;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL txn_timeout: master %0d got no ready in %0d cycles, expected one", m, budget);
      end
      @(posedge clk);
      #1;
      clear_master(m);
   endtask

   // ---------------- slave model ----------------
   initial begin
      int scnt;
      scnt = 0;
      bif.s_ready = 1'b0;
      bif.s_data_in = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (bif.busy) begin
            if (scnt == slave_delay) begin
               bif.s_ready = 1'b1;
               bif.s_data_in = slave_data;
            end else begin
               bif.s_ready = 1'b0;
               bif.s_data_in = 8'h00;
            end
            scnt++;
         end else begin
            scnt = 0;
            bif.s_ready = idle_noise;
            bif.s_data_in = idle_noise ? 8'hC3 : 8'h00;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      bit         prev_busy;
      bit         owner;
      logic [7:0] dat;
      logic [7:0] other;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bif.busy && !prev_busy) begin
            if (exp_s_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL grant: unexpected grant to %0d addr 0x%0h, expected none",
                        bif.grant, bif.s_address);
            end else begin
               check("slave_req", {13'd0, bif.grant, bif.s_read, bif.s_write,
                                   bif.s_address, bif.s_data_out},
                     {13'd0, exp_s_q.pop_front()});
            end
            grant_cyc[bif.grant] = cyc;
         end
         if (bif.m0_ready || bif.m1_ready) begin
            owner = bif.m1_ready;
            dat   = owner ? bif.m1_data_in : bif.m0_data_in;
            other = owner ? bif.m0_data_in : bif.m1_data_in;
            check("one_ready", 32'(bif.m0_ready & bif.m1_ready), 32'd0);
            check("other_data_in", 32'(other), 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ready: unexpected ready for master %0d, expected none", owner);
            end else begin
               check("master_resp", {22'd0, owner, dat, bif.bus_error},
                     {22'd0, exp_q.pop_front()});
            end
            ready_cyc[owner] = cyc;
         end else if (bif.bus_error) begin
            checks++;
            errors++;
            $display("FAIL bus_error: got 1 without ready, expected 0");
         end
         prev_busy = bif.busy;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      bit seen_busy;
      reset = 1'b1;
      clear_master(1'b0);
      clear_master(1'b1);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_busy",       32'(bif.busy), 32'd0);
      check("rst_grant",      32'(bif.grant), 32'd0);
      check("rst_s_address",  32'(bif.s_address), 32'd0);
      check("rst_s_data_out", 32'(bif.s_data_out), 32'd0);
      check("rst_strobes",    32'({bif.s_read, bif.s_write}), 32'd0);
      check("rst_bus_error",  32'(bif.bus_error), 32'd0);
      check("rst_readies",    32'({bif.m0_ready, bif.m1_ready}), 32'd0);

      // m0 read 0x3C, slave ready 2 cycles after s_read with 0xA5
      slave_delay = 2;
      slave_data  = 8'hA5;
      push_s(1'b0, 1'b1, 1'b0, 8'h3C, 8'h00);
      push_r(1'b0, 8'hA5, 1'b0);
      @(posedge clk); #1;
      master_txn(1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 20);
      check("lat_grant", 32'(grant_cyc[0] - req_cyc[0]), 32'd1);
      check("lat_ready", 32'(ready_cyc[0] - req_cyc[0]), 32'd3);

      // Tie right after reset: m0, then m1, then m0 again (it re-requests)
      apply_reset();
      slave_delay = 0;
      slave_data  = 8'h11;
      push_s(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
      push_s(1'b1, 1'b0, 1'b1, 8'h20, 8'h77);
      push_s(1'b0, 1'b1, 1'b0, 8'h12, 8'h00);
      push_r(1'b0, 8'h11, 1'b0);
      push_r(1'b1, 8'h11, 1'b0);
      push_r(1'b0, 8'h11, 1'b0);
      @(posedge clk); #1;
      fork
         begin
            master_txn(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 20);
            master_txn(1'b0, 1'b1, 1'b0, 8'h12, 8'h00, 20);
         end
         master_txn(1'b1, 1'b0, 1'b1, 8'h20, 8'h77, 20);
      join

      // m1 write waits behind a busy m0 read; one idle cycle in between
      slave_delay = 3;
      slave_data  = 8'h5A;
      push_s(1'b0, 1'b1, 1'b0, 8'h40, 8'h00);
      push_s(1'b1, 1'b0, 1'b1, 8'h80, 8'h55);
      push_r(1'b0, 8'h5A, 1'b0);
      push_r(1'b1, 8'h5A, 1'b0);
      @(posedge clk); #1;
      fork
         master_txn(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 20);
         begin
            repeat (2) @(posedge clk);
            #1;
            master_txn(1'b1, 1'b0, 1'b1, 8'h80, 8'h55, 30);
         end
      join
      check("idle_gap", 32'(grant_cyc[1] - ready_cyc[0]), 32'd2);

      // Read and write together: read wins, write suppressed
      slave_delay = 1;
      slave_data  = 8'h6E;
      push_s(1'b0, 1'b1, 1'b0, 8'h99, 8'hEE);
      push_r(1'b0, 8'h6E, 1'b0);
      @(posedge clk); #1;
      master_txn(1'b0, 1'b1, 1'b1, 8'h99, 8'hEE, 20);

      // s_ready while idle is ignored
      @(posedge clk); #1;
      idle_noise = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_sready_busy", 32'(bif.busy), 32'd0);
      end
      @(posedge clk); #1;
      idle_noise = 1'b0;
      @(posedge clk); #1;

      // Reset while BUSY drops the transaction without a ready
      slave_delay = -1;
      push_s(1'b0, 1'b1, 1'b0, 8'h33, 8'h00);
      bif.m0_read = 1'b1;
      bif.m0_address = 8'h33;
      seen_busy = 1'b0;
      for (int i = 0; i < 10 && !seen_busy; i++) begin
         @(negedge clk);
         seen_busy = bif.busy;
      end
      check("rst_busy_reached", 32'(seen_busy), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      clear_master(1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy",      32'(bif.busy), 32'd0);
      check("midrst_s_address", 32'(bif.s_address), 32'd0);
      check("midrst_strobes",   32'({bif.s_read, bif.s_write}), 32'd0);
      check("midrst_grant",     32'(bif.grant), 32'd0);

      // Slave never ready
      slave_delay = -1;
      push_s(1'b0, 1'b1, 1'b0, 8'h44, 8'h00);
`ifdef BUS_ARB_TIMEOUT_EN
      push_r(1'b0, 8'hFF, 1'b1);
      @(posedge clk); #1;
      master_txn(1'b0, 1'b1, 1'b0, 8'h44, 8'h00, 40);
      check("tmo_latency", 32'(ready_cyc[0] - grant_cyc[0]), 32'(TMO));
      @(negedge clk);
      check("tmo_idle", 32'(bif.busy), 32'd0);
`else
      @(posedge clk); #1;
      bif.m0_read = 1'b1;
      bif.m0_address = 8'h44;
      repeat (TMO + 10) @(negedge clk);
      check("stuck_busy", 32'(bif.busy), 32'd1);
      check("stuck_bus_error", 32'(bif.bus_error), 32'd0);
      apply_reset();
`endif

      repeat (3) @(posedge clk);
      check("exp_s_q_empty", 32'(exp_s_q.size()), 32'd0);
      check("exp_q_empty",   32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the 8-bit processor memory bus. It shares the single memory/peripheral bus between master 0 (the CPU) and master 1 (DMA/loader). Arbitration is round-robin, and a grant is held for one complete ready-terminated transaction. It sits between the masters' address/data/read/write/ready ports and the memory-side bus.

## Interface
Parameters:
- TIMEOUT, 15, number of cycles in BUSY without `s_ready` before abort (only used with BUS_ARB_TIMEOUT_EN); legal range 1..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_address, m1_address  in  8  master address.
- m0_data_out, m1_data_out  in  8  master write data.
- m0_read, m1_read  in  1  master read request.
- m0_write, m1_write  in  1  master write request.
- m0_data_in, m1_data_in  out  8  read data returned to master.
- m0_ready, m1_ready  out  1  one-cycle completion pulse to master.
- s_address  out  8  registered address to slave.
- s_data_out  out  8  registered write data to slave.
- s_read, s_write  out  1  registered strobes to slave.
- s_data_in  in  8  slave read data.
- s_ready  in  1  slave completion.
- grant  out  1  owning master (0/1), valid while busy.
- busy  out  1  transaction in flight.
- bus_error  out  1  one-cycle abort pulse (timeout build only).

## Operation
- Master request: `req_n = mN_read | mN_write`. A master holds address, data and strobes stable until it sees its `mN_ready`.
- If read and write are both asserted, the transaction is a read and write is suppressed.
- FSM has two states:
  - IDLE: if any request is pending, latch the winner's address, data and strobes into the `s_*` registers, set `grant`, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: `s_*` is held constant. On `s_ready`, clear `s_read`/`s_write` and go to IDLE.
- Round-robin: `last` is updated on every grant. If both masters request in IDLE, grant `~last`. A single requester always wins.
- Return path (combinational): `mN_ready = busy & s_ready & (grant==N)`. `mN_data_in = s_data_in` when `grant==N`, else 8'h00. The non-owner's ready is always 0.
- Reset values: state IDLE, `s_address`=0, `s_data_out`=0, `s_read`=0, `s_write`=0, `grant`=0, `last`=1 (so m0 wins the first tie), `busy`=0, `bus_error`=0, timeout counter=0.
- Reset during BUSY drops the transaction immediately. No ready pulse is issued for it.
- Requests arriving while BUSY wait. No preemption.

## Timing
- Request seen in cycle t (IDLE) → `s_*` valid and `busy`=1 in cycle t+1.
- `s_ready` in cycle k → `mN_ready` in cycle k (same cycle) → IDLE in k+1 with strobes low.
- The next grant is issued at the end of k+1. Back-to-back transactions therefore have one idle bus cycle between them.
- Minimum transaction (slave ready in first BUSY cycle): 2 cycles request-to-ready.
- `s_ready` sampled while IDLE is ignored.

## Configuration
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering BUSY and increments each BUSY cycle without `s_ready`.
  - When it reaches TIMEOUT, the arbiter aborts that cycle: owner `mN_ready`=1, `mN_data_in`=8'hFF, `bus_error`=1 for one cycle.
  - Next state is IDLE.
  - If `s_ready` arrives in the abort cycle, the normal completion wins and `bus_error` stays 0.
- Undefined: no counter. BUSY waits indefinitely. `bus_error` is tied 0.

## Test plan
- m0 read of 0x3C, slave ready 2 cycles after `s_read` with data 0xA5 → `s_address`=0x3C, `m0_ready` one pulse, `m0_data_in`=0xA5, `m1_ready` stays 0.
- m0 and m1 request together after reset → m0 granted first. If both re-request, m1 granted next, then m0 (alternating `grant` 0,1,0).
- m1 write 0x55 to 0x80 while m0 is BUSY → m1 waits. After m0 completes: one IDLE cycle, then `s_write`=1, `s_address`=0x80, `s_data_out`=0x55.
- m0 asserts read and write together → `s_read`=1, `s_write`=0.
- `reset` asserted during BUSY → next cycle all outputs are at reset values and no `mN_ready` pulse occurs.
- BUS_ARB_TIMEOUT_EN with TIMEOUT=15, slave never ready → after 15 BUSY cycles: `m0_ready`=1, `m0_data_in`=0xFF, `bus_error`=1 for one cycle, then IDLE. Without the macro, the arbiter stays BUSY.
